// File: rtl/dmux_pkg.sv
// Shared constants for the two-lane serial demux/deserializer.
// DMUX_DESER_PARITY_EN appends one even-parity bit to every frame.
package dmux_pkg;

`ifdef DMUX_DESER_PARITY_EN
    localparam int PARITY_BITS = 1;
`else
    localparam int PARITY_BITS = 0;
`endif

    localparam int DEFAULT_WIDTH = 8;
    localparam int FRAME_LEN     = DEFAULT_WIDTH + PARITY_BITS;
    localparam int CNT_W         = $clog2(FRAME_LEN);

    function automatic int frame_len(input int width);
        return width + PARITY_BITS;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + PARITY_BITS);
    endfunction

endpackage

// File: rtl/dmux_deser_lane.sv
// One deserializer lane: shift register, bit counter, single-word output slot, sticky flags.
// DMUX_DESER_PARITY_EN selects WIDTH+1-bit frames with a trailing even-parity bit.
module dmux_deser_lane
    import dmux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             y,
    input  logic             rdy,
    output logic [WIDTH-1:0] data,
    output logic             vld,
    output logic             ovf,
    output logic             perr
);
    localparam int              FRAME = frame_len(WIDTH);
    localparam int              CW    = cnt_width(WIDTH);
    localparam logic [CW-1:0]   LAST  = CW'(FRAME - 1);

    logic [WIDTH-1:0] sr;
    logic [CW-1:0]    cnt;
    logic             frame_done;
    logic             shift_en;
    logic             word_ok;
    logic [WIDTH-1:0] word;

    assign frame_done = bit_en && (cnt == LAST);

`ifdef DMUX_DESER_PARITY_EN
    // The parity bit is never shifted in; the word is already complete in sr.
    assign shift_en = bit_en && (cnt != LAST);
    assign word     = sr;
    assign word_ok  = frame_done && ((^sr) == y);
`else
    assign shift_en = bit_en;
    assign word     = {sr[WIDTH-2:0], y};
    assign word_ok  = frame_done;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            sr  <= '0;
        end else begin
            if (bit_en)
                cnt <= frame_done ? '0 : cnt + 1'b1;
            if (shift_en)
                sr <= {sr[WIDTH-2:0], y};
        end
    end

    // Handshake: a word transfers on any edge with vld=1 and rdy=1; data/vld hold
    // while vld=1 and rdy=0, and a word completing then is dropped and flags ovf.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            vld  <= 1'b0;
            ovf  <= 1'b0;
        end else if (word_ok) begin
            if (vld && !rdy) begin
                ovf <= 1'b1;
            end else begin
                data <= word;
                vld  <= 1'b1;
            end
        end else if (vld && rdy) begin
            vld <= 1'b0;
        end
    end

`ifdef DMUX_DESER_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            perr <= 1'b0;
        else if (frame_done && !word_ok)
            perr <= 1'b1;
    end
`else
    assign perr = 1'b0;
`endif

endmodule

// File: rtl/dmux_deser.sv
// Two-lane serial demultiplexer/deserializer; s steers each qualified bit to lane 0 or 1.
// DMUX_DESER_PARITY_EN enables per-frame even-parity checking (port list unchanged).
module dmux_deser
    import dmux_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_vld,
    input  logic             s,
    input  logic             y0,
    input  logic             y1,
    input  logic             rdy0,
    input  logic             rdy1,
    output logic [WIDTH-1:0] data0,
    output logic [WIDTH-1:0] data1,
    output logic             vld0,
    output logic             vld1,
    output logic             ovf0,
    output logic             ovf1,
    output logic             perr0,
    output logic             perr1
);
    logic bit_en0;
    logic bit_en1;

    assign bit_en0 = bit_vld && !s;
    assign bit_en1 = bit_vld && s;

    dmux_deser_lane #(.WIDTH(WIDTH)) u_lane0 (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bit_en0),
        .y      (y0),
        .rdy    (rdy0),
        .data   (data0),
        .vld    (vld0),
        .ovf    (ovf0),
        .perr   (perr0)
    );

    dmux_deser_lane #(.WIDTH(WIDTH)) u_lane1 (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bit_en1),
        .y      (y1),
        .rdy    (rdy1),
        .data   (data1),
        .vld    (vld1),
        .ovf    (ovf1),
        .perr   (perr1)
    );

endmodule

// File: tb/tb_dmux_deser.sv
// Bench for dmux_deser: directed scenarios plus randomized traffic against a frame-level model.
// Builds with or without DMUX_DESER_PARITY_EN.
module tb_dmux_deser;
    localparam int W = 8;
`ifdef DMUX_DESER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = W + PAR;

    logic         clk = 1'b0;
    logic         rst;
    logic         bit_vld = 1'b0;
    logic         s = 1'b0;
    logic         y0 = 1'b0;
    logic         y1 = 1'b0;
    logic         rdy0 = 1'b0;
    logic         rdy1 = 1'b0;
    logic [W-1:0] data0, data1;
    logic         vld0, vld1, ovf0, ovf1, perr0, perr1;

    int tests = 0;
    int fails = 0;
    int vld0_cnt = 0;
    int vld1_cnt = 0;

    dmux_deser #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst     (rst),
        .bit_vld (bit_vld),
        .s       (s),
        .y0      (y0),
        .y1      (y1),
        .rdy0    (rdy0),
        .rdy1    (rdy1),
        .data0   (data0),
        .data1   (data1),
        .vld0    (vld0),
        .vld1    (vld1),
        .ovf0    (ovf0),
        .ovf1    (ovf1),
        .perr0   (perr0),
        .perr1   (perr1)
    );

    // clock / reset
    always #5 clk = ~clk;
    initial rst = 1'b1;

    // model: frames accumulated as integers, one output slot per lane
    int           m_n[2]    = '{0, 0};
    logic [W:0]   m_acc[2]  = '{'0, '0};
    logic [W-1:0] m_data[2] = '{'0, '0};
    logic         m_vld[2]  = '{1'b0, 1'b0};
    logic         m_ovf[2]  = '{1'b0, 1'b0};
    logic         m_perr[2] = '{1'b0, 1'b0};
    logic [W-1:0] exp_q0[$];
    logic [W-1:0] exp_q1[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < 2; l++) begin
                m_n[l] = 0; m_acc[l] = '0; m_data[l] = '0;
                m_vld[l] = 1'b0; m_ovf[l] = 1'b0; m_perr[l] = 1'b0;
            end
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int l = 0; l < 2; l++) begin
                logic         en, yb, rd, done, good;
                logic [W-1:0] word;
                en   = bit_vld && (int'(s) == l);
                yb   = (l == 0) ? y0 : y1;
                rd   = (l == 0) ? rdy0 : rdy1;
                done = 1'b0;
                good = 1'b1;
                word = '0;
                if (en) begin
                    m_acc[l] = (m_acc[l] << 1) | (W+1)'(yb);
                    m_n[l]   = m_n[l] + 1;
                    if (m_n[l] == FRAME) begin
                        done = 1'b1;
                        word = (PAR == 1) ? m_acc[l][W:1] : m_acc[l][W-1:0];
                        good = (PAR == 0) || ($countones(m_acc[l]) % 2 == 0);
                        m_n[l]   = 0;
                        m_acc[l] = '0;
                    end
                end
                if (done && good) begin
                    if (m_vld[l] && !rd) begin
                        m_ovf[l] = 1'b1;
                    end else begin
                        m_data[l] = word;
                        m_vld[l]  = 1'b1;
                        if (l == 0) exp_q0.push_back(word);
                        else        exp_q1.push_back(word);
                    end
                end else if (m_vld[l] && rd) begin
                    m_vld[l] = 1'b0;
                end
                if (done && !good)
                    m_perr[l] = 1'b1;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: every cycle against the model, every transfer against the expected queue
    always @(negedge clk) begin
        check("data0", 32'(data0), 32'(m_data[0]));
        check("vld0",  32'(vld0),  32'(m_vld[0]));
        check("ovf0",  32'(ovf0),  32'(m_ovf[0]));
        check("perr0", 32'(perr0), 32'(m_perr[0]));
        check("data1", 32'(data1), 32'(m_data[1]));
        check("vld1",  32'(vld1),  32'(m_vld[1]));
        check("ovf1",  32'(ovf1),  32'(m_ovf[1]));
        check("perr1", 32'(perr1), 32'(m_perr[1]));
        if (vld0) vld0_cnt++;
        if (vld1) vld1_cnt++;
        if (!rst && vld0 && rdy0) begin
            if (exp_q0.size() == 0) check("xfer0_unexpected", 32'(data0), 32'hFFFF_FFFF);
            else                    check("xfer0_word", 32'(data0), 32'(exp_q0.pop_front()));
        end
        if (!rst && vld1 && rdy1) begin
            if (exp_q1.size() == 0) check("xfer1_unexpected", 32'(data1), 32'hFFFF_FFFF);
            else                    check("xfer1_word", 32'(data1), 32'(exp_q1.pop_front()));
        end
    end

    // driver tasks
    task automatic wait_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input int lane, input logic b);
        wait_edge();
        bit_vld = 1'b1;
        s = (lane != 0);
        if (lane == 0) y0 = b;
        else           y1 = b;
    endtask

    task automatic idle();
        wait_edge();
        bit_vld = 1'b0;
    endtask

    task automatic send_word(input int lane, input logic [W-1:0] w, input logic flip);
        for (int i = W - 1; i >= 0; i--) send_bit(lane, w[i]);
        if (PAR == 1) send_bit(lane, (^w) ^ flip);
    endtask

    task automatic do_reset();
        wait_edge();
        rst = 1'b1;
        bit_vld = 1'b0;
        wait_edge();
        rst = 1'b0;
    endtask

    int c0, c1;

    initial begin
        rdy0 = 1'b1;
        rdy1 = 1'b1;
        wait_edge();
        wait_edge();
        check("rst_data0", 32'(data0), 32'h0);
        check("rst_vld0",  32'(vld0),  32'h0);
        check("rst_vld1",  32'(vld1),  32'h0);
        check("rst_ovf1",  32'(ovf1),  32'h0);
        rst = 1'b0;

        // A5 on lane 0, lane 1 untouched
        send_word(0, 8'hA5, 1'b0);
        idle();
        check("a5_data0", 32'(data0), 32'hA5);
        check("a5_vld0",  32'(vld0),  32'h1);
        check("a5_data1", 32'(data1), 32'h0);
        check("a5_vld1",  32'(vld1),  32'h0);
        idle();
        check("a5_vld0_drop", 32'(vld0), 32'h0);

        // interleaved 3C / C3
        c0 = vld0_cnt;
        c1 = vld1_cnt;
        begin
            logic [W-1:0] w0, w1;
            w0 = 8'h3C;
            w1 = 8'hC3;
            for (int i = W - 1; i >= 0; i--) begin
                send_bit(0, w0[i]);
                send_bit(1, w1[i]);
            end
            if (PAR == 1) begin
                send_bit(0, ^w0);
                send_bit(1, ^w1);
            end
        end
        idle();
        check("il_data0", 32'(data0), 32'h3C);
        check("il_data1", 32'(data1), 32'hC3);
        check("il_vld1",  32'(vld1),  32'h1);
        idle();
        idle();
        check("il_pulses0", 32'(vld0_cnt - c0), 32'h1);
        check("il_pulses1", 32'(vld1_cnt - c1), 32'h1);

        // overflow while lane 0 is stalled
        rdy0 = 1'b0;
        send_word(0, 8'h11, 1'b0);
        send_word(0, 8'h22, 1'b0);
        idle();
        check("ovf_data0", 32'(data0), 32'h11);
        check("ovf_vld0",  32'(vld0),  32'h1);
        check("ovf_ovf0",  32'(ovf0),  32'h1);
        rdy0 = 1'b1;
        idle();
        check("ovf_vld0_drop", 32'(vld0), 32'h0);
        check("ovf_sticky",    32'(ovf0), 32'h1);

        // lane 1 replace: ready arrives on the edge 55 completes
        do_reset();
        rdy1 = 1'b0;
        send_word(1, 8'hAA, 1'b0);
        for (int i = W - 1; i >= 0; i--) send_bit(1, i[0] ? 1'b0 : 1'b1);
        if (PAR == 1) send_bit(1, ^8'h55);
        rdy1 = 1'b1;
        idle();
        check("rep_vld1",  32'(vld1),  32'h1);
        check("rep_data1", 32'(data1), 32'h55);
        check("rep_ovf1",  32'(ovf1),  32'h0);
        idle();

        // reset mid-frame discards the partial frame
        for (int i = 0; i < 4; i++) send_bit(0, 1'b1);
        wait_edge();
        bit_vld = 1'b0;
        rst = 1'b1;
        #1;
        check("mid_rst_data0", 32'(data0), 32'h0);
        wait_edge();
        rst = 1'b0;
        send_word(0, 8'hF0, 1'b0);
        idle();
        check("f0_data0", 32'(data0), 32'hF0);
        check("f0_vld0",  32'(vld0),  32'h1);
        idle();

`ifdef DMUX_DESER_PARITY_EN
        do_reset();
        send_word(0, 8'h01, 1'b1);
        idle();
        check("par_bad_vld0",  32'(vld0),  32'h0);
        check("par_bad_perr0", 32'(perr0), 32'h1);
        check("par_bad_data0", 32'(data0), 32'h0);
        send_word(0, 8'h01, 1'b0);
        idle();
        check("par_ok_data0", 32'(data0), 32'h01);
        check("par_ok_vld0",  32'(vld0),  32'h1);
        idle();
`else
        check("noparity_perr0", 32'(perr0), 32'h0);
`endif

        // randomized traffic, checked every cycle by the scoreboard
        for (int n = 0; n < 3000; n++) begin
            wait_edge();
            rst     = ($urandom_range(0, 399) == 0);
            bit_vld = ($urandom_range(0, 9) < 7);
            s       = 1'($urandom_range(0, 1));
            y0      = 1'($urandom_range(0, 1));
            y1      = 1'($urandom_range(0, 1));
            rdy0    = ($urandom_range(0, 9) < 6);
            rdy1    = ($urandom_range(0, 9) < 6);
        end
        wait_edge();
        rst = 1'b0;
        bit_vld = 1'b0;
        wait_edge();
        wait_edge();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
